gray_frame_ctrl: RTL and testbench
==================================

Name: gray_frame_ctrl

Overview:
- Frame sequencer for the rgb2gray grayscale datapath.
- Gates the source→rgb2gray and rgb2gray→sink valid/ready handshakes for one frame of a programmed width × height.
- Carries per-pixel sof/eol/eof sideband alongside the elastic pipeline through a tag FIFO, so sideband stays aligned with gray_o regardless of stalls.
- Reports busy/done per frame; pixel data never passes through this block.

Parameters:
- DIM_W_P, 12, width of frame width/height and x/y counters.
- TAG_DEPTH_P, 4, tag FIFO entries; must be ≥ maximum datapath occupancy (rgb2gray holds up to 4 tokens); power of two.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  start-frame pulse; honoured only in IDLE.
- abort_i  in  1  stop ingress for the current frame.
- width_i  in  DIM_W_P  pixels per line; sampled on accepted start.
- height_i  in  DIM_W_P  lines per frame; sampled on accepted start.
- busy_o  out  1  high in RUN or DRAIN.
- done_o  out  1  one-cycle pulse at frame completion.
- aborted_o  out  1  valid with done_o; frame ended by abort.
- err_o  out  1  sticky; datapath produced output with tag FIFO empty.
- pix_valid_i  in  1  source pixel valid.
- pix_ready_o  out  1  to source.
- dp_valid_o  out  1  to rgb2gray valid_i.
- dp_ready_i  in  1  from rgb2gray ready_o.
- dp_valid_i  in  1  from rgb2gray valid_o.
- dp_ready_o  out  1  to rgb2gray ready_i.
- out_valid_o  out  1  to sink.
- out_ready_i  in  1  from sink.
- out_sof_o  out  1  first pixel of frame; qualified by out_valid_o.
- out_eol_o  out  1  last pixel of line; qualified by out_valid_o.
- out_eof_o  out  1  last pixel of frame; qualified by out_valid_o.

Behaviour:
- Reset values (while rstn_i low): state IDLE; x, y, FIFO pointers and count cleared; busy_o, done_o, aborted_o, err_o = 0. All handshake outputs deasserted.
- States: IDLE, RUN, DRAIN.
- IDLE → RUN: start_i=1 with width_i≠0 and height_i≠0. Latch width_i and height_i; x=y=0. A start with a zero dimension is ignored (stays IDLE, no done).
- Ingress gate: open = (state==RUN) & !fifo_full, where fifo_full uses the registered count (no same-cycle pop bypass).
  - dp_valid_o = pix_valid_i & open.
  - pix_ready_o = dp_ready_i & open.
  - Accept = dp_valid_o & dp_ready_i.
- On each accept:
  - Push tag {sof = (x==0 & y==0), eol = (x==w-1), eof = (x==w-1 & y==h-1)}.
  - Advance x; at line end wrap x to 0 and increment y.
- RUN → DRAIN: on the accept with eof=1, or on abort_i=1 in RUN (set aborted flag). An accept in the same cycle as abort_i is still pushed; if that pixel is eof, aborted stays 0.
- Egress: nonempty = fifo count ≠ 0. No added latency; combinational gating only.
  - out_valid_o = dp_valid_i & nonempty.
  - dp_ready_o = out_ready_i & nonempty.
  - out_sof_o / out_eol_o / out_eof_o = FIFO head fields.
  - Pop = out_valid_o & out_ready_i.
  - Egress is active in every state, so tokens drain after abort.
- Simultaneous push and pop: count unchanged; both pointers advance, wrapping modulo TAG_DEPTH_P.
- DRAIN → IDLE: when FIFO count is 0 (including a pop that empties it this cycle).
  - done_o pulses the following cycle.
  - aborted_o equals the aborted flag during that pulse; the flag clears on the next accepted start.
- err_o: set when dp_valid_i=1 and the FIFO is empty. Cleared only by reset. dp_ready_o stays 0 in that case.
- abort_i in IDLE or DRAIN: ignored. start_i in RUN or DRAIN: ignored.
- Asynchronous reset mid-frame: all state drops immediately; in-flight datapath tokens become orphaned and will raise err_o. Integration must reset both blocks together.

Decomposition:
- Shared package gray_pkg:
  - state enum ctrl_state_e {IDLE, RUN, DRAIN}.
  - Packed struct frame_tag_t {sof, eol, eof}.
  - Localparam RGB2GRAY_OCCUPANCY = 4.
- One sub-module: tag_fifo, a synchronous FIFO of frame_tag_t with depth TAG_DEPTH_P, exposing count/full/empty and asynchronous active-low reset. Counters and FSM stay in the top.

Test Plan:
- 4×2 frame, no stalls, real rgb2gray attached → exactly 8 egress handshakes.
  - sof on output 1 only; eol on outputs 4 and 8; eof on output 8.
  - done_o high for exactly one cycle after the 8th pop; aborted_o = 0.
- 4×2 frame with out_ready_i held low → ingress stalls once the tag FIFO fills (4 tags).
  - Release out_ready_i → remaining pixels flow; tags stay aligned to gray_o values.
- Random pix_valid_i / out_ready_i (50%) over a 17×3 frame → 51 outputs; eol on every 17th; single eof; no err_o.
- abort_i asserted after 5 accepts in a 8×8 frame → ingress closes; the 5 in-flight tokens drain; done_o with aborted_o = 1.
  - Next start with 2×1 → sof on output 1; eof on output 2.
- Edge cases:
  - start_i with width_i = 0 → stays IDLE; busy_o = 0; no done_o.
  - start_i pulsed during RUN → ignored; frame completes normally.
  - dp_valid_i forced high in IDLE → err_o sets and remains 1 until rstn_i is asserted.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types for the grayscale frame sequencer: FSM states, per-pixel sideband tag
// and the rgb2gray pipeline occupancy the tag FIFO must cover.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } frame_tag_t;

  localparam int RGB2GRAY_OCCUPANCY = 4;

endpackage

// File: rtl/gray_frame_ctrl_tag_fifo.sv
// Synchronous FIFO of frame tags; pushes while full and pops while empty are dropped.
module tag_fifo
  import gray_pkg::*;
#(
  parameter  int DEPTH_P = 4,
  localparam int PTR_W   = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1,
  localparam int CNT_W   = $clog2(DEPTH_P + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  frame_tag_t       wdata_i,
  input  logic             pop_i,
  output frame_tag_t       rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  frame_tag_t       mem_q [DEPTH_P];
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH_P));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gray_frame_ctrl.sv
// Frame sequencer around the rgb2gray datapath: gates ingress/egress handshakes and
// carries sof/eol/eof through a tag FIFO so sideband stays aligned with the gray output.
module gray_frame_ctrl
  import gray_pkg::*;
#(
  parameter int DIM_W_P     = 12,
  parameter int TAG_DEPTH_P = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [DIM_W_P-1:0] width_i,
  input  logic [DIM_W_P-1:0] height_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic               err_o,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  output logic               dp_valid_o,
  input  logic               dp_ready_i,
  input  logic               dp_valid_i,
  output logic               dp_ready_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_sof_o,
  output logic               out_eol_o,
  output logic               out_eof_o
);

  localparam int CNT_W = $clog2(TAG_DEPTH_P + 1);

  if (TAG_DEPTH_P < RGB2GRAY_OCCUPANCY) begin : g_depth_check
    $error("TAG_DEPTH_P smaller than rgb2gray occupancy");
  end

  ctrl_state_e        state_q, state_d;
  logic [DIM_W_P-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic               aborted_q, aborted_d, done_q, done_d, err_q, err_d;
  logic               fifo_full, fifo_empty, gate_open, accept, pop;
  logic               line_end, frame_end, drain_empty;
  logic [CNT_W-1:0]   fifo_count;
  frame_tag_t         push_tag, head_tag;

  // Ingress: full is taken from the registered count, no same-cycle pop bypass.
  assign gate_open   = (state_q == RUN) && !fifo_full;
  assign dp_valid_o  = pix_valid_i & gate_open;
  assign pix_ready_o = dp_ready_i & gate_open;
  assign accept      = dp_valid_o & dp_ready_i;

  assign line_end  = (x_q == w_q - DIM_W_P'(1));
  assign frame_end = line_end && (y_q == h_q - DIM_W_P'(1));
  assign push_tag  = '{sof: (x_q == '0) && (y_q == '0), eol: line_end, eof: frame_end};

  // Egress runs in every state so tokens still drain after abort.
  assign out_valid_o = dp_valid_i & ~fifo_empty;
  assign dp_ready_o  = out_ready_i & ~fifo_empty;
  assign pop         = out_valid_o & out_ready_i;
  assign out_sof_o   = head_tag.sof;
  assign out_eol_o   = head_tag.eol;
  assign out_eof_o   = head_tag.eof;

  assign drain_empty = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign aborted_o = done_q & aborted_q;
  assign err_o     = err_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    err_d     = err_q | (dp_valid_i & fifo_empty);
    unique case (state_q)
      IDLE: begin
        if (start_i && (width_i != '0) && (height_i != '0)) begin
          state_d   = RUN;
          w_d       = width_i;
          h_d       = height_i;
          x_d       = '0;
          y_d       = '0;
          aborted_d = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          if (line_end) begin
            x_d = '0;
            y_d = y_q + DIM_W_P'(1);
          end else begin
            x_d = x_q + DIM_W_P'(1);
          end
        end
        // A last-pixel accept wins over a coincident abort: the frame is complete.
        if (accept && frame_end) begin
          state_d = DRAIN;
        end else if (abort_i) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  tag_fifo #(
    .DEPTH_P (TAG_DEPTH_P)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (accept),
    .wdata_i (push_tag),
    .pop_i   (pop),
    .rdata_o (head_tag),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_gray_frame_ctrl.sv
// Directed bench for gray_frame_ctrl with a 4-deep elastic stand-in for rgb2gray that
// carries each pixel's accept index, so output sideband can be checked against data.
module tb_gray_frame_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic [11:0] width = '0, height = '0;
  logic        busy, done, aborted, err;
  logic        pix_valid = 1'b0, pix_ready;
  logic        dp_valid_o, dp_ready_i, dp_valid_i, dp_ready_o;
  logic        out_valid, out_ready = 1'b0;
  logic        out_sof, out_eol, out_eof;
  logic        force_dpv = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int dp_mem [4];
  int dp_wr = 0, dp_rd = 0, dp_cnt = 0, acc_total = 0;
  int out_total = 0, done_cnt = 0;
  int last_ab = 0;
  int log_sof [512], log_eol [512], log_eof [512], log_data [512];
  logic m_push, m_pop;

  always #5 clk = ~clk;

  gray_frame_ctrl #(.DIM_W_P(12), .TAG_DEPTH_P(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
    .width_i(width), .height_i(height),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_o(err),
    .pix_valid_i(pix_valid), .pix_ready_o(pix_ready),
    .dp_valid_o(dp_valid_o), .dp_ready_i(dp_ready_i),
    .dp_valid_i(dp_valid_i), .dp_ready_o(dp_ready_o),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sof_o(out_sof), .out_eol_o(out_eol), .out_eof_o(out_eof)
  );

  // Datapath stand-in: up to 4 tokens, one-cycle minimum latency.
  assign dp_ready_i = (dp_cnt < 4);
  assign dp_valid_i = (dp_cnt > 0) | force_dpv;
  assign m_push     = dp_valid_o & dp_ready_i;
  assign m_pop      = dp_valid_i & dp_ready_o & (dp_cnt > 0);

  always @(posedge clk) begin
    if (!rstn) begin
      dp_cnt <= 0;
      dp_wr  <= 0;
      dp_rd  <= 0;
    end else begin
      if (m_push) begin
        dp_mem[dp_wr] <= acc_total;
        dp_wr         <= (dp_wr + 1) % 4;
        acc_total     <= acc_total + 1;
      end
      if (m_pop) dp_rd <= (dp_rd + 1) % 4;
      dp_cnt <= dp_cnt + int'(m_push) - int'(m_pop);
    end
  end

  // Inputs only change just after posedge, so mid-cycle values hold until the next edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      log_sof[out_total]  <= int'(out_sof);
      log_eol[out_total]  <= int'(out_eol);
      log_eof[out_total]  <= int'(out_eof);
      log_data[out_total] <= dp_mem[dp_rd];
      out_total           <= out_total + 1;
    end
    if (rstn && done) begin
      done_cnt <= done_cnt + 1;
      last_ab  <= int'(aborted);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int w, input int h);
    @(posedge clk); #1;
    width  = 12'(w);
    height = 12'(h);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      if (rnd) begin
        pix_valid = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end
      n++;
    end
    chk("done_seen", int'(done_cnt != d0), 1);
    pix_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_frame(input int ob, input int d0, input int n_exp,
                             input int w, input int h, input int ab_exp);
    int n;
    repeat (4) @(posedge clk);
    #1;
    n = out_total - ob;
    chk("n_out", n, n_exp);
    chk("done_pulses", done_cnt - d0, 1);
    chk("aborted", last_ab, ab_exp);
    chk("busy_after", int'(busy), 0);
    for (int k = 0; k < n && k < n_exp; k++) begin
      chk("sof", log_sof[ob+k], int'(k == 0));
      chk("eol", log_eol[ob+k], int'((k % w) == w - 1));
      chk("eof", log_eof[ob+k], int'(k == w * h - 1));
      chk("data", log_data[ob+k], ob + k);
    end
  endtask

  initial begin
    int ob, d0, ab, n;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_pix_ready", int'(pix_ready), 0);
    chk("rst_dp_valid", int'(dp_valid_o), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dp_ready", int'(dp_ready_o), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    pix_valid = 1'b0;

    // 4x2 frame, no stalls
    ob = out_total; d0 = done_cnt;
    pix_valid = 1'b1;
    start_frame(4, 2);
    chk("busy_run", int'(busy), 1);
    wait_done(d0, 200, 1'b0);
    check_frame(ob, d0, 8, 4, 2, 0);

    // 4x2 frame with sink stalled: ingress stops at four tags
    ob = out_total; d0 = done_cnt; ab = acc_total;
    pix_valid = 1'b1;
    out_ready = 1'b0;
    start_frame(4, 2);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_accepts", acc_total - ab, 4);
    chk("stall_pix_ready", int'(pix_ready), 0);
    chk("stall_out_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    wait_done(d0, 200, 1'b0);
    check_frame(ob, d0, 8, 4, 2, 0);

    // 17x3 frame with random valid/ready
    ob = out_total; d0 = done_cnt;
    pix_valid = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    start_frame(17, 3);
    wait_done(d0, 2000, 1'b1);
    check_frame(ob, d0, 51, 17, 3, 0);
    chk("rand_err", int'(err), 0);

    // abort after five accepts in an 8x8 frame
    ob = out_total; d0 = done_cnt; ab = acc_total;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    start_frame(8, 8);
    n = 0;
    while (acc_total - ab < 5 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    pix_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    pix_valid = 1'b1;
    chk("abort_accepts", acc_total - ab, 5);
    chk("abort_closed", int'(pix_ready), 0);
    wait_done(d0, 200, 1'b0);
    check_frame(ob, d0, 5, 8, 8, 1);

    // 2x1 frame after abort
    ob = out_total; d0 = done_cnt;
    pix_valid = 1'b1;
    start_frame(2, 1);
    wait_done(d0, 200, 1'b0);
    check_frame(ob, d0, 2, 2, 1, 0);

    // zero-width start is ignored
    d0 = done_cnt;
    pix_valid = 1'b1;
    start_frame(0, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_busy", int'(busy), 0);
    chk("zero_done", done_cnt - d0, 0);
    chk("zero_pix_ready", int'(pix_ready), 0);

    // start pulsed during RUN is ignored
    ob = out_total; d0 = done_cnt;
    pix_valid = 1'b1;
    out_ready = 1'b0;
    start_frame(4, 2);
    repeat (3) @(posedge clk);
    start_frame(2, 1);
    out_ready = 1'b1;
    wait_done(d0, 200, 1'b0);
    check_frame(ob, d0, 8, 4, 2, 0);

    // datapath output with empty tag FIFO sets sticky err
    chk("err_before", int'(err), 0);
    force_dpv = 1'b1;
    #2;
    chk("orphan_dp_ready", int'(dp_ready_o), 0);
    @(posedge clk); #1;
    force_dpv = 1'b0;
    chk("err_set", int'(err), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", int'(err), 1);
    rstn = 1'b0;
    #2;
    chk("err_cleared", int'(err), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
